// File: rtl/barrier_sync.sv
// barrier_sync: registered completion-pin bus plus an armed barrier with release and timeout
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   in_pins          : raw completion pins, registered onto out_bus
//   pin_mask, start  : participating pins, sampled on the start pulse that arms the barrier
//   captured         : sticky record of arrived masked pins
//   missing          : masked pins still absent when the timeout fired
//   busy, barrier_done, barrier_release, timeout : WAIT, DONE, entry-to-DONE pulse, TIMEOUT
module barrier_sync #(
  parameter int NUM_PINS = 5,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PINS-1:0] in_pins,
  input  logic [NUM_PINS-1:0] pin_mask,
  input  logic                start,
  output logic [NUM_PINS-1:0] out_bus,
  output logic [NUM_PINS-1:0] captured,
  output logic [NUM_PINS-1:0] missing,
  output logic                busy,
  output logic                barrier_done,
  output logic                barrier_release,
  output logic                timeout
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_TMO} state_t;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
  state_t              r_state, w_next;
  logic [NUM_PINS-1:0] r_mask, w_hit;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rel, w_rel, w_all, w_exp;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      out_bus  <= '0;
      r_mask   <= '0;
      captured <= '0;
      missing  <= '0;
      r_cnt    <= '0;
      r_rel    <= 1'b0;
    end else begin
      r_state <= w_next;
      out_bus <= in_pins;
      r_rel   <= w_rel;
      if (start) begin
        r_mask   <= pin_mask;
        captured <= '0;
        missing  <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_WAIT) begin
        captured <= w_hit;
        if (~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
        if (!w_all && w_exp) missing <= r_mask & ~w_hit;
      end
    end
  end
  // final arrival beats counter expiry in the same clock
  always_comb begin
    w_hit  = captured | (out_bus & r_mask);
    w_all  = w_hit == r_mask;
    w_exp  = (TIMEOUT != 0) && (r_cnt == LP_LAST);
    w_next = r_state;
    w_rel  = 1'b0;
    if (start) begin
      w_next = (pin_mask == '0) ? S_DONE : S_WAIT;
      w_rel  = pin_mask == '0;
    end else if (r_state == S_WAIT) begin
      w_next = w_all ? S_DONE : (w_exp ? S_TMO : S_WAIT);
      w_rel  = w_all;
    end
  end
  assign busy            = r_state == S_WAIT;
  assign barrier_done    = r_state == S_DONE;
  assign timeout         = r_state == S_TMO;
  assign barrier_release = r_rel;
endmodule

// File: tb/tb_barrier_sync.sv
// tb_barrier_sync: directed and randomized checks of barrier_sync against an event-level model
module tb_barrier_sync;
  localparam int N   = 5;
  localparam int TMO = 16;
  logic clk = 0, reset = 1, start = 0;
  logic [N-1:0] in_pins = '0, pin_mask = '0;
  logic [N-1:0] out_bus, captured, missing;
  logic busy, barrier_done, barrier_release, timeout;
  int vec = 0, err = 0;
  barrier_sync #(.NUM_PINS(N), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_pins(in_pins), .pin_mask(pin_mask), .start(start),
    .out_bus(out_bus), .captured(captured), .missing(missing), .busy(busy),
    .barrier_done(barrier_done), .barrier_release(barrier_release), .timeout(timeout)
  );
  always #5 clk = ~clk;
  // model: phase 0 idle, 1 waiting, 2 done, 3 timed out; m_wt counts clocks spent waiting
  int m_ph = 0, m_wt = 0;
  logic [N-1:0] m_out = '0, m_mask = '0, m_cap = '0, m_miss = '0;
  logic m_rel = 0;
  logic [3*N+3:0] obs;
  assign obs = {out_bus, captured, missing, busy, barrier_done, barrier_release, timeout};
  function automatic logic [3*N+3:0] expv();
    return {m_out, m_cap, m_miss, m_ph == 1, m_ph == 2, m_rel, m_ph == 3};
  endfunction
  task automatic tick(input logic rs, input logic st, input logic [N-1:0] mk, input logic [N-1:0] pn);
    logic [N-1:0] arr;
    reset = rs; start = st; pin_mask = mk; in_pins = pn;
    @(posedge clk);
    arr = m_cap | (m_out & m_mask);
    m_rel = 0;
    if (rs) begin
      m_ph = 0; m_wt = 0; m_mask = '0; m_cap = '0; m_miss = '0;
    end else if (st) begin
      m_mask = mk; m_cap = '0; m_miss = '0; m_wt = 0;
      m_ph = (mk == '0) ? 2 : 1;
      m_rel = mk == '0;
    end else if (m_ph == 1) begin
      m_cap = arr;
      m_wt++;
      if (arr == m_mask) begin m_ph = 2; m_rel = 1; end
      else if (TMO != 0 && m_wt == TMO) begin m_ph = 3; m_miss = m_mask & ~arr; end
    end
    m_out = rs ? '0 : pn;
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(i < 2, 0, '0, 5'b10110);
      vec++; if (obs !== expv()) begin err++; $display("FAIL reset i=%0d got=%h want=%h", i, obs, expv()); end
      if (i == 1) begin vec++; if (obs !== '0) begin err++; $display("FAIL reset_zero got=%h want=0", obs); end end
    end
  endtask
  task automatic test_capture();
    for (int i = 0; i < 8; i++) begin
      tick(0, i == 0, 5'b11111, (i >= 1 && i <= 5) ? N'(1 << (i - 1)) : '0);
      vec++; if (obs !== expv()) begin err++; $display("FAIL capture i=%0d got=%h want=%h", i, obs, expv()); end
      if (i >= 2 && i <= 6) begin vec++; if (captured !== N'((1 << (i - 1)) - 1)) begin err++; $display("FAIL capture_step i=%0d got=%b want=%b", i, captured, N'((1 << (i - 1)) - 1)); end end
      if (i == 5) begin vec++; if (barrier_release !== 0) begin err++; $display("FAIL early_release got=%b want=0", barrier_release); end end
      if (i == 6) begin vec++; if ({barrier_release, barrier_done, timeout} !== 3'b110) begin err++; $display("FAIL release got=%b want=110", {barrier_release, barrier_done, timeout}); end end
      if (i == 7) begin vec++; if ({barrier_release, barrier_done, timeout} !== 3'b010) begin err++; $display("FAIL done_hold got=%b want=010", {barrier_release, barrier_done, timeout}); end end
    end
  endtask
  task automatic test_timeout();
    for (int i = 0; i < 18; i++) begin
      tick(0, i == 0, 5'b10101, i == 0 ? '0 : 5'b01010);
      vec++; if (obs !== expv()) begin err++; $display("FAIL timeout i=%0d got=%h want=%h", i, obs, expv()); end
      vec++; if (captured !== '0) begin err++; $display("FAIL unmasked_cap i=%0d got=%b want=00000", i, captured); end
      if (i == 15) begin vec++; if ({busy, timeout} !== 2'b10) begin err++; $display("FAIL pre_timeout got=%b want=10", {busy, timeout}); end end
      if (i == 16) begin vec++; if ({busy, timeout, missing} !== 7'b0110101) begin err++; $display("FAIL timeout_hit got=%b want=0110101", {busy, timeout, missing}); end end
    end
  endtask
  task automatic test_race();
    for (int i = 0; i < 18; i++) begin
      tick(0, i == 0, 5'b00011, i == 1 ? 5'b00001 : (i == 15 ? 5'b00010 : '0));
      vec++; if (obs !== expv()) begin err++; $display("FAIL race i=%0d got=%h want=%h", i, obs, expv()); end
      if (i == 15) begin vec++; if (busy !== 1) begin err++; $display("FAIL race_busy got=%b want=1", busy); end end
      if (i == 16) begin vec++; if ({barrier_done, barrier_release, timeout, missing} !== 8'b11000000) begin err++; $display("FAIL race_done got=%b want=11000000", {barrier_done, barrier_release, timeout, missing}); end end
      if (i == 17) begin vec++; if ({barrier_done, barrier_release, timeout} !== 3'b100) begin err++; $display("FAIL race_hold got=%b want=100", {barrier_done, barrier_release, timeout}); end end
    end
  endtask
  task automatic test_empty_mask();
    for (int i = 0; i < 3; i++) begin
      tick(0, i == 0, '0, 5'b11111);
      vec++; if (obs !== expv()) begin err++; $display("FAIL empty i=%0d got=%h want=%h", i, obs, expv()); end
      vec++; if ({busy, barrier_done, barrier_release} !== (i == 0 ? 3'b011 : 3'b010)) begin err++; $display("FAIL empty_flags i=%0d got=%b want=%b", i, {busy, barrier_done, barrier_release}, i == 0 ? 3'b011 : 3'b010); end
    end
  endtask
  task automatic test_mid_reset();
    for (int i = 0; i < 7; i++) begin
      tick(i == 4, i == 0 || i == 5, 5'b11111, i == 1 ? 5'b00010 : (i == 2 ? 5'b00100 : '0));
      vec++; if (obs !== expv()) begin err++; $display("FAIL midreset i=%0d got=%h want=%h", i, obs, expv()); end
      if (i == 3) begin vec++; if (captured !== 5'b00110) begin err++; $display("FAIL midreset_cap got=%b want=00110", captured); end end
      if (i == 4) begin vec++; if (obs !== '0) begin err++; $display("FAIL midreset_zero got=%h want=0", obs); end end
      if (i == 5) begin vec++; if ({busy, captured} !== 6'b100000) begin err++; $display("FAIL rearm got=%b want=100000", {busy, captured}); end end
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 21; i++) begin
      tick(0, i == 0 || i == 17, 5'b00100, i == 18 ? 5'b00100 : '0);
      vec++; if (obs !== expv()) begin err++; $display("FAIL b2b i=%0d got=%h want=%h", i, obs, expv()); end
      if (i == 16) begin vec++; if ({timeout, missing} !== 6'b100100) begin err++; $display("FAIL b2b_to got=%b want=100100", {timeout, missing}); end end
      if (i == 17) begin vec++; if ({busy, timeout, missing} !== 7'b1000000) begin err++; $display("FAIL b2b_rearm got=%b want=1000000", {busy, timeout, missing}); end end
      if (i == 18) begin vec++; if (out_bus !== 5'b00100) begin err++; $display("FAIL b2b_bus got=%b want=00100", out_bus); end end
      if (i == 19) begin vec++; if ({barrier_release, barrier_done} !== 2'b11) begin err++; $display("FAIL b2b_rel got=%b want=11", {barrier_release, barrier_done}); end end
      if (i == 20) begin vec++; if ({barrier_release, barrier_done} !== 2'b01) begin err++; $display("FAIL b2b_hold got=%b want=01", {barrier_release, barrier_done}); end end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0, N'($urandom), N'($urandom & $urandom & $urandom));
      vec++; if (obs !== expv()) begin err++; $display("FAIL random i=%0d got=%h want=%h", i, obs, expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_capture();
    test_timeout();
    test_race();
    test_empty_mask();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/barrier_sync.md
Name: barrier_sync

Overview:
- Parametrised successor to the fixed five-pin barrier glue.
- Registers NUM_PINS completion pins and passes them out as a bus.
- Adds an armed barrier: it records which participating pins have asserted, issues a release when every masked pin has arrived, and flags a timeout with the list of missing pins.
- Sits between per-channel completion indicators (checkers, DMA, MAC testers) and the sim/system controller that waits for all channels.

Parameters:
- NUM_PINS, 5: number of barrier input pins (1..32).
- TIMEOUT, 1024: clocks allowed in WAIT before a timeout is flagged. 0 disables the timeout.
- CNT_W, 32: width of the timeout counter. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_pins  in  NUM_PINS  raw completion pins; level or pulse, minimum 1 clk wide.
- pin_mask  in  NUM_PINS  1 = pin participates; sampled only on start.
- start  in  1  1-clk pulse that arms or re-arms the barrier.
- out_bus  out  NUM_PINS  in_pins registered once.
- captured  out  NUM_PINS  sticky record of arrived masked pins.
- missing  out  NUM_PINS  mask & ~captured, latched on timeout.
- busy  out  1  high in WAIT.
- barrier_done  out  1  level, high in DONE.
- barrier_release  out  1  1-clk pulse on entry to DONE.
- timeout  out  1  level, high in TIMEOUT.

Behaviour:
- Reset:
  - State IDLE.
  - out_bus, captured, missing, internal mask and counter all cleared to 0.
  - busy, barrier_done, barrier_release and timeout all 0.
  - Reset takes priority over start and over any state, including mid-WAIT.
- out_bus <= in_pins every clock, in every state (1-clk latency).
- States are IDLE, WAIT, DONE and TIMEOUT.
- start, in any state (not under reset):
  - Latches mask_r <= pin_mask.
  - Clears captured, missing and counter.
  - Next state is WAIT.
  - If pin_mask == 0, next state is DONE directly, with a release pulse.
  - Pins on out_bus in the start cycle are ignored; capture begins the following clock.
- WAIT:
  - captured <= captured | (out_bus & mask_r).
  - Counter increments by 1 per clock.
  - If (captured | (out_bus & mask_r)) == mask_r, next state is DONE. barrier_release is high for exactly the first cycle in DONE.
  - Otherwise, if TIMEOUT != 0 and counter == TIMEOUT-1, next state is TIMEOUT and missing <= mask_r & ~(captured | (out_bus & mask_r)).
  - If the final capture and counter expiry occur in the same clock, DONE wins and timeout stays 0.
- Capture latency: an in_pins assertion sampled at edge N appears on out_bus after N. It is ORed into captured at edge N+1. barrier_release is visible after edge N+1 when that pin is the last one.
- Unmasked pins never set captured bits, but they still appear on out_bus.
- DONE and TIMEOUT hold, with captured frozen, until the next start or reset. A pin deasserting after capture does not clear its bit.
- busy = (state == WAIT). barrier_done = (state == DONE). timeout = (state == TIMEOUT).
- The counter saturates and never wraps. It is unused when TIMEOUT = 0, and WAIT then persists indefinitely.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan (NUM_PINS=5, TIMEOUT=16):
1. Reset, then start with pin_mask=5'b11111. Pulse pins 0..4 one per clock in ascending order. Required: captured steps 00001 → 11111. barrier_release is a single-cycle pulse 2 clks after the pin4 pulse. barrier_done stays high, timeout=0.
2. start with mask=5'b10101. Assert pins 1 and 3 only. Required: captured stays 00000. After 16 clks in WAIT, timeout=1, missing=10101, busy=0.
3. start with mask=5'b00011. Assert pin0, then pin1 arriving in the clock where the counter reaches 15. Required: DONE is entered, release pulses once, timeout=0, missing=00000.
4. start with pin_mask=5'b00000. Required: the next clock has barrier_done=1 and release=1 for one clock, busy never asserts.
5. Mid-WAIT with captured=00110, assert reset for 1 clk. Required: all outputs 0 and state IDLE. A following start with mask=11111 shows captured=00000.
6. In TIMEOUT (missing=00100), pulse start with mask=00100, then pulse pin2. Required: missing clears, busy=1, then release pulses once and barrier_done=1. out_bus tracks in_pins with 1-clk latency throughout.
